// File: rtl/sdram_test_sequencer.sv
// sdram_test_sequencer: fills a word range with an LFSR pattern, reads it back and counts miscompares, pass after pass.
// Optional first-miscompare capture ports are enabled by defining SDRAM_SEQ_ERRLOG_EN.
module sdram_test_sequencer #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              start,
  input  logic              stop_on_error,
  output logic              ctl_req,
  output logic              ctl_we,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_ack,
  input  logic              ctl_rvalid,
  input  logic [DATA_W-1:0] ctl_rdata,
  output logic              busy,
  output logic [1:0]        phase,
  output logic [15:0]       pass_count,
  output logic [15:0]       err_count
`ifdef SDRAM_SEQ_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              first_err_valid
`endif
);
  typedef enum logic [2:0] {IDLE, FILL, VREQ, VWAIT, PEND, HALT} state_t;
  localparam logic [15:0] SEED0 = (SEED == 16'h0) ? 16'h1 : SEED;
  state_t state;
  logic [15:0] lfsr;
  logic [15:0] seed_r;
  logic last;
  logic miss;
  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction
  // ctl_addr doubles as the walking address and ctl_wdata is the live pattern word
  assign ctl_wdata = lfsr[DATA_W-1:0];
  assign busy = phase[0] ^ phase[1];
  assign last = &ctl_addr;
  assign miss = ctl_rdata != lfsr[DATA_W-1:0];
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state <= IDLE;
      lfsr <= '0;
      seed_r <= SEED0;
      ctl_req <= 1'b0;
      ctl_we <= 1'b0;
      ctl_addr <= '0;
      phase <= 2'd0;
      pass_count <= '0;
      err_count <= '0;
`ifdef SDRAM_SEQ_ERRLOG_EN
      first_err_addr <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      first_err_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          lfsr <= seed_r;
          ctl_addr <= '0;
          ctl_req <= 1'b1;
          ctl_we <= 1'b1;
          phase <= 2'd1;
          state <= FILL;
        end
        FILL: if (ctl_ack) begin
          ctl_addr <= ctl_addr + ADDR_W'(1);
          lfsr <= last ? seed_r : step(lfsr);
          ctl_we <= !last;
          phase <= last ? 2'd2 : 2'd1;
          state <= last ? VREQ : FILL;
        end
        VREQ: if (ctl_ack) begin
          ctl_req <= 1'b0;
          state <= VWAIT;
        end
        VWAIT: if (ctl_rvalid) begin
          if (miss) begin
            err_count <= err_count + 16'(~&err_count);
`ifdef SDRAM_SEQ_ERRLOG_EN
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_addr <= ctl_addr;
              first_err_exp <= lfsr[DATA_W-1:0];
              first_err_act <= ctl_rdata;
            end
`endif
          end
          if (miss && stop_on_error) begin
            phase <= 2'd3;
            state <= HALT;
          end else begin
            lfsr <= step(lfsr);
            ctl_addr <= ctl_addr + ADDR_W'(1);
            ctl_req <= !last;
            state <= last ? PEND : VREQ;
          end
        end
        PEND: begin
          pass_count <= pass_count + 16'd1;
          seed_r <= step(seed_r);
          lfsr <= step(seed_r);
          ctl_addr <= '0;
          ctl_req <= start;
          ctl_we <= start;
          phase <= start ? 2'd1 : 2'd0;
          state <= start ? FILL : IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_test_sequencer.sv
// tb_sdram_test_sequencer: scoreboard bench for sdram_test_sequencer against a behavioural memory responder.
`timescale 1ns/1ps
module tb_sdram_test_sequencer;
  localparam int AW = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic start = 1'b0;
  logic stop_on_error = 1'b0;
  logic ctl_req, ctl_we, busy;
  logic ctl_ack = 1'b0;
  logic ctl_rvalid = 1'b0;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata;
  logic [DW-1:0] ctl_rdata = '0;
  logic [1:0] phase;
  logic [15:0] pass_count, err_count;
`ifdef SDRAM_SEQ_ERRLOG_EN
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_exp, first_err_act;
  logic first_err_valid;
`endif
  int vectors = 0;
  int errors = 0;
  logic [DW-1:0] mem [16];
  logic [20:0] exp_q [$];
  int fault = 0;      // 0 clean, 1 addr 5 bit 3 stuck high, 2 every read inverted
  int stall_left = 0; // extra ack delay for the next write to addr 7
  logic [15:0] sb_seed = 16'hACE1;
  int sb_err = 0;

  sdram_test_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SEED(16'hACE1)) dut (
    .clk(clk), .reset_in(reset_in), .start(start), .stop_on_error(stop_on_error),
    .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_ack(ctl_ack), .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata),
    .busy(busy), .phase(phase), .pass_count(pass_count), .err_count(err_count)
`ifdef SDRAM_SEQ_ERRLOG_EN
    , .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act), .first_err_valid(first_err_valid)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_step(input logic [15:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic logic [15:0] pat_at(input logic [15:0] seed, input int a);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < a; i++) s = f_step(s);
    return s;
  endfunction

  function automatic int first_bad_pass();
    logic [15:0] s, p;
    s = 16'hACE1;
    for (int i = 0; i < 64; i++) begin
      p = pat_at(s, 5);
      if (!p[3]) return i;
      s = f_step(s);
    end
    return 0;
  endfunction

  task automatic push_pass(input logic [15:0] seed);
    logic [15:0] s;
    s = seed;
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back({1'b1, 4'(a), s});
      s = f_step(s);
    end
    s = seed;
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back({1'b0, 4'(a), 16'h0});
      if (fault == 2 || (fault == 1 && a == 5 && !s[3])) sb_err = (sb_err < 65535) ? sb_err + 1 : 65535;
      s = f_step(s);
    end
  endtask

  // memory responder: ack one cycle after req (or stalled), rvalid three cycles after a read ack
  initial begin : responder
    int wait_n;
    int rv_cnt;
    logic [DW-1:0] rd;
    logic [20:0] held, obs, e;
    wait_n = 0;
    rv_cnt = 0;
    rd = '0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      ctl_ack = 1'b0;
      ctl_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt = rv_cnt - 1;
        if (rv_cnt == 0) begin
          ctl_rvalid = 1'b1;
          ctl_rdata = rd;
        end
      end
      if (!reset_in || !ctl_req) wait_n = 0;
      else begin
        if (wait_n == 0) held = {ctl_we, ctl_addr, ctl_wdata};
        else begin
          vectors++;
          if ({ctl_we, ctl_addr, ctl_wdata} !== held) begin
            errors++;
            $display("FAIL req_stable: got %h, held %h", {ctl_we, ctl_addr, ctl_wdata}, held);
          end
        end
        if (wait_n >= ((ctl_we && ctl_addr == 4'd7 && stall_left > 0) ? stall_left : 1)) begin
          ctl_ack = 1'b1;
          wait_n = 0;
          if (ctl_we && ctl_addr == 4'd7) stall_left = 0;
          obs = ctl_we ? held : {held[20:16], 16'h0};
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL txn_order: got unexpected %h, expected none", obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              errors++;
              $display("FAIL txn_order: got %h, expected %h", obs, e);
            end
          end
          if (ctl_we) mem[ctl_addr] = ctl_wdata;
          else begin
            rd = mem[ctl_addr];
            if (fault == 2) rd = ~rd;
            if (fault == 1 && ctl_addr == 4'd5) rd = rd | 16'h0008;
            rv_cnt = 3;
          end
        end else wait_n++;
      end
    end
  end

  task automatic wait_phase(input logic [1:0] p, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (phase == p);
    end
  endtask

  task automatic wait_count(input logic [15:0] pc, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (pass_count == pc);
    end
  endtask

  task automatic run_passes(input int n, output bit ok);
    logic [15:0] pc0;
    bit w;
    pc0 = pass_count;
    push_pass(sb_seed);
    start = 1'b1;
    wait_phase(2'd1, ok);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) start = 1'b0;
      wait_count(pc0 + 16'(i + 1), w);
      ok &= w;
      sb_seed = f_step(sb_seed);
      if (i < n - 1) push_pass(sb_seed);
    end
    wait_phase(2'd0, w);
    ok &= w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_in = 1'b0;
    start = 1'b0;
    stop_on_error = 1'b0;
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    exp_q.delete();
    sb_seed = 16'hACE1;
    sb_err = 0;
    fault = 0;
    stall_left = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ctl_req, ctl_we, ctl_addr, ctl_wdata, busy, phase, pass_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", {ctl_req, ctl_we, ctl_addr, ctl_wdata, busy, phase, pass_count, err_count});
    end
`ifdef SDRAM_SEQ_ERRLOG_EN
    vectors++;
    if ({first_err_addr, first_err_exp, first_err_act, first_err_valid} !== '0) begin
      errors++;
      $display("FAIL reset_errlog: got %h, expected 0", {first_err_addr, first_err_exp, first_err_act, first_err_valid});
    end
`endif
  endtask

  task automatic test_ideal();
    bit ok;
    do_reset();
    run_passes(1, ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ideal_p0_timeout: got %0d, expected 1", ok); end
    vectors++;
    if (mem[0] !== 16'hACE1) begin errors++; $display("FAIL ideal_p0_addr0: got %h, expected ace1", mem[0]); end
    vectors++;
    if (mem[1] !== 16'hE270) begin errors++; $display("FAIL ideal_p0_addr1: got %h, expected e270", mem[1]); end
    vectors++;
    if ({pass_count, err_count} !== {16'd1, 16'd0}) begin
      errors++;
      $display("FAIL ideal_p0_counts: got %h/%h, expected 0001/0000", pass_count, err_count);
    end
    vectors++;
    if ({busy, phase} !== 3'b000) begin errors++; $display("FAIL ideal_idle: got %b, expected 000", {busy, phase}); end
    run_passes(1, ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ideal_p1_timeout: got %0d, expected 1", ok); end
    vectors++;
    if (mem[0] !== 16'hE270) begin errors++; $display("FAIL ideal_p1_addr0: got %h, expected e270", mem[0]); end
    vectors++;
    if ({pass_count, err_count, 32'(exp_q.size())} !== {16'd2, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL ideal_p1_counts: got %h/%h left %0d, expected 0002/0000 left 0", pass_count, err_count, exp_q.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    stall_left = 20;
    push_pass(sb_seed);
    start = 1'b1;
    wait_phase(2'd1, ok);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b, expected 1", busy); end
    start = 1'b0;
    wait_count(16'd1, ok);
    sb_seed = f_step(sb_seed);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %0d, expected 1", ok); end
    vectors++;
    if ({32'(exp_q.size()), 32'(stall_left), err_count} !== {32'd0, 32'd0, 16'd0}) begin
      errors++;
      $display("FAIL stall_sequence: got left %0d stall %0d err %h, expected 0 0 0000", exp_q.size(), stall_left, err_count);
    end
  endtask

  task automatic test_fault_continue();
    bit ok;
    int n;
    do_reset();
    fault = 1;
    n = first_bad_pass() + 3;
    run_passes(n, ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL fault_timeout: got %0d, expected 1", ok); end
    vectors++;
    if (err_count !== 16'(sb_err)) begin errors++; $display("FAIL fault_err_count: got %0d, expected %0d", err_count, sb_err); end
    vectors++;
    if (pass_count !== 16'(n)) begin errors++; $display("FAIL fault_pass_count: got %0d, expected %0d", pass_count, n); end
  endtask

  task automatic test_fault_halt();
    bit ok, req_seen;
    int pf;
    logic [15:0] s;
    do_reset();
    fault = 1;
    stop_on_error = 1'b1;
    pf = first_bad_pass();
    s = sb_seed;
    for (int p = 0; p <= pf; p++) begin
      if (p == pf) sb_seed = s;
      push_pass(s);
      s = f_step(s);
    end
    start = 1'b1;
    wait_phase(2'd3, ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL halt_timeout: got %0d, expected 1", ok); end
    vectors++;
    if ({busy, err_count, pass_count} !== {1'b0, 16'd1, 16'(pf)}) begin
      errors++;
      $display("FAIL halt_state: got busy %b err %0d pass %0d, expected 0 1 %0d", busy, err_count, pass_count, pf);
    end
    vectors++;
    if (exp_q.size() != 10) begin errors++; $display("FAIL halt_position: got %0d left, expected 10", exp_q.size()); end
`ifdef SDRAM_SEQ_ERRLOG_EN
    vectors++;
    if ({first_err_valid, first_err_addr, first_err_exp, first_err_act} !== {1'b1, 4'd5, pat_at(sb_seed, 5), pat_at(sb_seed, 5) | 16'h0008}) begin
      errors++;
      $display("FAIL halt_errlog: got %b %h %h %h, expected 1 5 %h %h", first_err_valid, first_err_addr, first_err_exp, first_err_act, pat_at(sb_seed, 5), pat_at(sb_seed, 5) | 16'h0008);
    end
`endif
    req_seen = 0;
    repeat (100) begin
      @(negedge clk);
      req_seen |= ctl_req;
    end
    vectors++;
    if ({req_seen, phase, err_count} !== {1'b0, 2'd3, 16'd1}) begin
      errors++;
      $display("FAIL halt_hold: got req %b phase %0d err %0d, expected 0 3 1", req_seen, phase, err_count);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    fault = 2;
    push_pass(sb_seed);
    start = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (phase == 2'd2 && !ctl_req);
    end
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL mid_reach_wait: got %0d, expected 1", ok); end
    reset_in = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ctl_req, ctl_we, ctl_addr, ctl_wdata, busy, phase, pass_count, err_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, expected 0", {ctl_req, ctl_we, ctl_addr, ctl_wdata, busy, phase, pass_count, err_count});
    end
    reset_in = 1'b1;
    exp_q.delete();
    sb_seed = 16'hACE1;
    sb_err = 0;
    repeat (10) @(negedge clk);
    vectors++;
    if ({ctl_req, phase, err_count} !== '0) begin
      errors++;
      $display("FAIL mid_late_rvalid: got req %b phase %0d err %0d, expected 0 0 0", ctl_req, phase, err_count);
    end
    fault = 0;
    push_pass(sb_seed);
    start = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ctl_req && ctl_we;
    end
    vectors++;
    if ({ok, ctl_addr, ctl_wdata} !== {1'b1, 4'd0, 16'hACE1}) begin
      errors++;
      $display("FAIL mid_restart: got %b %h %h, expected 1 0 ace1", ok, ctl_addr, ctl_wdata);
    end
    start = 1'b0;
    wait_count(16'd1, ok);
    sb_seed = f_step(sb_seed);
    vectors++;
    if ({ok, err_count, 32'(exp_q.size())} !== {1'b1, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL mid_restart_pass: got %b err %0d left %0d, expected 1 0 0", ok, err_count, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    bit ok;
    do_reset();
    force dut.err_count = 16'hFFFE;
    @(negedge clk);
    release dut.err_count;
    @(negedge clk);
    sb_err = 65534;
    vectors++;
    if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h, expected fffe", err_count); end
    fault = 2;
    run_passes(1, ok);
    vectors++;
    if ({ok, err_count} !== {1'b1, 16'(sb_err)}) begin
      errors++;
      $display("FAIL sat_first: got %b %h, expected 1 %h", ok, err_count, 16'(sb_err));
    end
    run_passes(1, ok);
    vectors++;
    if ({ok, err_count, pass_count} !== {1'b1, 16'hFFFF, 16'd2}) begin
      errors++;
      $display("FAIL sat_hold: got %b %h %0d, expected 1 ffff 2", ok, err_count, pass_count);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_stall();
    test_fault_continue();
    test_fault_halt();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
